// File: rtl/buzzer_pkg.sv
// Shared definitions for the buzzer melody sequencer.
//   - note frequency constants in Hz (NOTE_REST = silence)
//   - sequencer state enum
//   - note table entry layout {freq, dur} and a constructor helper
package buzzer_pkg;

  localparam int FREQ_W = 10;
  localparam int DUR_W  = 10;

  localparam int NOTE_REST = 0;
  localparam int NOTE_C4   = 262;
  localparam int NOTE_D4   = 294;
  localparam int NOTE_E4   = 330;
  localparam int NOTE_F4   = 349;
  localparam int NOTE_G4   = 392;
  localparam int NOTE_A4   = 440;
  localparam int NOTE_B4   = 494;
  localparam int NOTE_C5   = 523;
  localparam int NOTE_D5   = 587;
  localparam int NOTE_E5   = 659;
  localparam int NOTE_F5   = 698;
  localparam int NOTE_G5   = 784;
  localparam int NOTE_A5   = 880;
  localparam int NOTE_B5   = 988;
  // C6 does not fit the 10-bit frequency field; tables stop at B5.
  localparam int NOTE_C6   = 1047;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, ADV, DONE} state_t;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [DUR_W-1:0]  dur;
  } note_t;

  function automatic note_t mk_note(input int freq, input int dur);
    note_t n;
    n.freq = FREQ_W'(freq);
    n.dur  = DUR_W'(dur);
    return n;
  endfunction

endpackage

// File: rtl/buzzer_melody_rom.sv
// Synchronous-read note table. The entry for addr appears on data one
// clock later. dur == 0 marks the end of the melody; freq == 0 is a rest.
// MELODY selects one of the built-in tables (0 = the product tune).
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (clears the read register)
//   addr  in   note index
//   data  out  registered {freq, dur}
module buzzer_melody_rom
  import buzzer_pkg::*;
#(
  parameter int MELODY = 0,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] addr,
  output note_t            data
);

  function automatic note_t lookup(input int a);
    note_t n;
    n = mk_note(NOTE_REST, 0);
    case (MELODY)
      1: case (a)
           0: n = mk_note(NOTE_A4, 3);
           default: n = mk_note(NOTE_REST, 0);
         endcase
      2: case (a)
           0: n = mk_note(NOTE_C4, 2);
           1: n = mk_note(NOTE_REST, 2);
           2: n = mk_note(NOTE_E4, 1);
           default: n = mk_note(NOTE_REST, 0);
         endcase
      3: case (a)
           0:  n = mk_note(NOTE_C4, 1);
           1:  n = mk_note(NOTE_D4, 1);
           2:  n = mk_note(NOTE_E4, 1);
           3:  n = mk_note(NOTE_F4, 1);
           4:  n = mk_note(NOTE_G4, 1);
           5:  n = mk_note(NOTE_A4, 1);
           6:  n = mk_note(NOTE_B4, 1);
           7:  n = mk_note(NOTE_C5, 1);
           8:  n = mk_note(NOTE_D5, 1);
           9:  n = mk_note(NOTE_E5, 1);
           10: n = mk_note(NOTE_F5, 1);
           11: n = mk_note(NOTE_G5, 1);
           12: n = mk_note(NOTE_A5, 1);
           13: n = mk_note(NOTE_B5, 1);
           14: n = mk_note(NOTE_C5, 1);
           default: n = mk_note(NOTE_C4, 1);
         endcase
      default: case (a)
           0:  n = mk_note(NOTE_C4, 250);
           1:  n = mk_note(NOTE_C4, 250);
           2:  n = mk_note(NOTE_G4, 250);
           3:  n = mk_note(NOTE_G4, 250);
           4:  n = mk_note(NOTE_A4, 250);
           5:  n = mk_note(NOTE_A4, 250);
           6:  n = mk_note(NOTE_G4, 500);
           7:  n = mk_note(NOTE_F4, 250);
           8:  n = mk_note(NOTE_F4, 250);
           9:  n = mk_note(NOTE_E4, 250);
           10: n = mk_note(NOTE_E4, 250);
           11: n = mk_note(NOTE_D4, 250);
           12: n = mk_note(NOTE_D4, 250);
           13: n = mk_note(NOTE_C4, 500);
           default: n = mk_note(NOTE_REST, 0);
         endcase
    endcase
    return n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data <= '0;
    else     data <= lookup(int'(addr));
  end

endmodule

// File: rtl/buzzer_melody_sequencer.sv
// Melody sequencer: steps through the note table, drives the tone divider
// frequency word and the buzzer enable, holding each note for its duration
// followed by a silent gap.
// Build option: define MELODY_LOOP_EN to repeat the melody until i_stop.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_start         start request, honoured only in IDLE
//   i_stop          abort, wins over i_start
//   o_value         tone frequency in Hz (held through rests and gaps)
//   o_tone_en       buzzer enable
//   o_busy          high outside IDLE
//   o_note_idx      current table index
//   o_done          one-cycle pulse at normal end of melody
//
// state | meaning
// IDLE  | waiting for i_start
// LOAD  | ROM data for o_note_idx valid; end marker check
// PLAY  | note (or rest) sounding for dur ticks
// GAP   | silent GAP_TICKS ticks between notes
// ADV   | step to next index or finish
// DONE  | o_done pulse
module buzzer_melody_sequencer
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int NOTE_COUNT = 16,
  parameter int GAP_TICKS  = 20,
  parameter int MELODY     = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_start,
  input  logic                          i_stop,
  output logic [FREQ_W-1:0]             o_value,
  output logic                          o_tone_en,
  output logic                          o_busy,
  output logic [$clog2(NOTE_COUNT)-1:0] o_note_idx,
  output logic                          o_done
);

  localparam int IDX_W    = $clog2(NOTE_COUNT);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t            state, state_nxt;
  logic [PRE_W-1:0]  presc, presc_nxt;
  logic [DUR_W-1:0]  cnt, cnt_nxt;
  logic [FREQ_W-1:0] cur_freq, cur_freq_nxt, play_freq;
  logic [FREQ_W-1:0] value_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              tone_nxt, busy_nxt, done_nxt;
  logic              tick, cnt_tc, last_idx;
  note_t             rom_q;

  // The ROM is addressed with the next index so its registered output is
  // valid during the LOAD cycle that follows.
  buzzer_melody_rom #(.MELODY(MELODY), .IDX_W(IDX_W)) u_rom (
    .clk  (i_clk),
    .rst  (i_reset),
    .addr (idx_nxt),
    .data (rom_q)
  );

  assign tick     = (presc == PRE_W'(TICK_DIV - 1));
  assign cnt_tc   = tick && (cnt == DUR_W'(1));
  assign last_idx = (o_note_idx == IDX_W'(NOTE_COUNT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      presc      <= '0;
      cnt        <= '0;
      cur_freq   <= '0;
      o_value    <= '0;
      o_tone_en  <= 1'b0;
      o_busy     <= 1'b0;
      o_note_idx <= '0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      presc      <= presc_nxt;
      cnt        <= cnt_nxt;
      cur_freq   <= cur_freq_nxt;
      o_value    <= value_nxt;
      o_tone_en  <= tone_nxt;
      o_busy     <= busy_nxt;
      o_note_idx <= idx_nxt;
      o_done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state != IDLE && i_stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (i_start && !i_stop) state_nxt = LOAD;
        LOAD: state_nxt = (rom_q.dur == '0) ? DONE : PLAY;
        PLAY: if (cnt_tc) state_nxt = (GAP_TICKS == 0) ? ADV : GAP;
        GAP:  if (cnt_tc) state_nxt = ADV;
        ADV:  state_nxt = last_idx ? DONE : LOAD;
`ifdef MELODY_LOOP_EN
        // An end marker at index 0 would loop with zero length; stop instead.
        DONE: state_nxt = (o_note_idx == '0) ? IDLE : LOAD;
`else
        DONE: state_nxt = IDLE;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of every registered output and counter, derived from the
  // transition so that o_value and o_tone_en change on the same edge.
  always_comb begin
    play_freq = (state == LOAD) ? rom_q.freq : cur_freq;
    busy_nxt  = (state_nxt != IDLE);
    tone_nxt  = (state_nxt == PLAY) && (play_freq != '0);
    done_nxt  = (state_nxt == DONE);

    idx_nxt = o_note_idx;
    if (state == IDLE || state == DONE || state_nxt == IDLE)
      idx_nxt = '0;
    else if (state == ADV && state_nxt == LOAD)
      idx_nxt = o_note_idx + 1'b1;

    value_nxt = o_value;
    if (state_nxt == IDLE)
      value_nxt = '0;
    else if (state == LOAD && state_nxt == PLAY && rom_q.freq != '0)
      value_nxt = rom_q.freq;

    cur_freq_nxt = cur_freq;
    if (state_nxt == IDLE)  cur_freq_nxt = '0;
    else if (state == LOAD) cur_freq_nxt = rom_q.freq;

    // Prescaler only runs while staying in PLAY/GAP, so it restarts at 0
    // on every entry.
    presc_nxt = '0;
    if ((state == PLAY || state == GAP) && state_nxt == state)
      presc_nxt = tick ? '0 : presc + 1'b1;

    cnt_nxt = cnt;
    if (state_nxt == IDLE)
      cnt_nxt = '0;
    else if (state == LOAD)
      cnt_nxt = rom_q.dur;
    else if (state == PLAY && state_nxt == GAP)
      cnt_nxt = DUR_W'(GAP_TICKS);
    else if ((state == PLAY || state == GAP) && tick)
      cnt_nxt = cnt - 1'b1;
  end

endmodule

// File: tb/tb_buzzer_melody_sequencer.sv
module tb_buzzer_melody_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 0, stop_a = 0, start_b = 0, stop_b = 0, start_c = 0, stop_c = 0;
  logic [9:0] val_a, val_b, val_c;
  logic [3:0] idx_a, idx_b, idx_c;
  logic te_a, te_b, te_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

  always #5 clk = ~clk;

  buzzer_melody_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .NOTE_COUNT(16),
                            .GAP_TICKS(2), .MELODY(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_stop(stop_a),
    .o_value(val_a), .o_tone_en(te_a), .o_busy(busy_a),
    .o_note_idx(idx_a), .o_done(done_a));

  buzzer_melody_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .NOTE_COUNT(16),
                            .GAP_TICKS(2), .MELODY(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_stop(stop_b),
    .o_value(val_b), .o_tone_en(te_b), .o_busy(busy_b),
    .o_note_idx(idx_b), .o_done(done_b));

  buzzer_melody_sequencer #(.CLK_HZ(1000), .TICK_HZ(100), .NOTE_COUNT(16),
                            .GAP_TICKS(2), .MELODY(3)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_start(start_c), .i_stop(stop_c),
    .o_value(val_c), .o_tone_en(te_c), .o_busy(busy_c),
    .o_note_idx(idx_c), .o_done(done_c));

  // Melody 3: sixteen one-tick notes.
  int mel [16] = '{262, 294, 330, 349, 392, 440, 494, 523,
                   587, 659, 698, 784, 880, 988, 523, 262};

  // Scoreboard of expected output runs: a tuple held for len cycles
  // (len 0 = any length).
  typedef struct {
    logic [16:0] tup;
    int          len;
  } run_t;

  run_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          sel = 0;
  bit          tracking = 0;
  logic [16:0] cur;
  int          run_len;
  logic [16:0] obs;

  always_comb begin
    case (sel)
      0:       obs = {busy_a, te_a, done_a, val_a, idx_a};
      1:       obs = {busy_b, te_b, done_b, val_b, idx_b};
      default: obs = {busy_c, te_c, done_c, val_c, idx_c};
    endcase
  end

  function automatic logic [16:0] tp(input bit b, input bit t, input bit d,
                                     input int v, input int i);
    return {b, t, d, 10'(v), 4'(i)};
  endfunction

  function automatic string fmt(input logic [16:0] t);
    return $sformatf("busy=%0b tone=%0b done=%0b value=%0d idx=%0d",
                     t[16], t[15], t[14], t[13:4], t[3:0]);
  endfunction

  task automatic expect_run(input bit b, input bit t, input bit d,
                            input int v, input int i, input int len);
    run_t r;
    r.tup = tp(b, t, d, v, i);
    r.len = len;
    sb.push_back(r);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic close_run();
    run_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL run_unexpected observed=(%s len=%0d) expected=none", fmt(cur), run_len);
    end else begin
      e = sb.pop_front();
      assert (cur === e.tup) else begin
        errors++;
        $error("FAIL run_tuple observed=(%s) expected=(%s)", fmt(cur), fmt(e.tup));
      end
      if (e.len != 0) begin
        checks++;
        assert (run_len === e.len) else begin
          errors++;
          $error("FAIL run_length (%s) observed=%0d expected=%0d", fmt(e.tup), run_len, e.len);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    checks++;
    assert (((obs[15] == 1'b1) && (obs[13:4] == 10'd0)) === 1'b0) else begin
      errors++;
      $error("FAIL tone_with_zero_value observed=(%s) expected=value nonzero", fmt(obs));
    end
    if (tracking) begin
      if (obs !== cur) begin
        close_run();
        cur     = obs;
        run_len = 1;
      end else begin
        run_len++;
      end
    end
  endtask

  task automatic begin_seq(input int s);
    sel = s;
    #1;
    cur      = obs;
    run_len  = 1;
    tracking = 1;
  endtask

  task automatic end_seq();
    close_run();
    tracking = 0;
    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL runs_left observed=%0d expected=0", sb.size());
    end
  endtask

  initial begin
    // Power-on reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tone", te_a, 0);
    chk("reset_value", val_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_idx", idx_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_busy_b", busy_b, 0);
    chk("reset_busy_c", busy_c, 0);
    rst = 1'b0;

    // Reset asserted mid-PLAY clears outputs immediately.
    sel = 0;
    start_a = 1; step(); start_a = 0;
    repeat (14) step();
    chk("pre_reset_tone", te_a, 1);
    chk("pre_reset_value", val_a, 440);
    #2 rst = 1'b1;
    #1;
    chk("midreset_tone", te_a, 0);
    chk("midreset_value", val_a, 0);
    chk("midreset_busy", busy_a, 0);
    chk("midreset_idx", idx_a, 0);
    chk("midreset_done", done_a, 0);
    #1 rst = 1'b0;
    repeat (3) step();
    chk("post_reset_busy", busy_a, 0);

    // Single note {440,3} then end marker; start re-pulsed during PLAY.
    begin_seq(0);
    expect_run(0, 0, 0, 0, 0, 0);
    expect_run(1, 0, 0, 0, 0, 1);
    expect_run(1, 1, 0, 440, 0, 30);
    expect_run(1, 0, 0, 440, 0, 21);
    expect_run(1, 0, 0, 440, 1, 1);
    expect_run(1, 0, 1, 440, 1, 1);
`ifdef MELODY_LOOP_EN
    expect_run(1, 0, 0, 440, 0, 1);
    expect_run(1, 1, 0, 440, 0, 30);
    expect_run(1, 0, 0, 440, 0, 21);
    expect_run(1, 0, 0, 440, 1, 1);
    expect_run(1, 0, 1, 440, 1, 1);
    expect_run(1, 0, 0, 440, 0, 1);
    expect_run(1, 1, 0, 440, 0, 5);
`endif
    expect_run(0, 0, 0, 0, 0, 0);
    start_a = 1; step(); start_a = 0;
    repeat (10) step();
    start_a = 1; step(); start_a = 0;
`ifdef MELODY_LOOP_EN
    repeat (102) step();
    stop_a = 1; step(); stop_a = 0;
    repeat (5) step();
`else
    repeat (70) step();
`endif
    end_seq();

    // Note, rest, note: value held through the rest.
    begin_seq(1);
    expect_run(0, 0, 0, 0, 0, 0);
    expect_run(1, 0, 0, 0, 0, 1);
    expect_run(1, 1, 0, 262, 0, 20);
    expect_run(1, 0, 0, 262, 0, 21);
    expect_run(1, 0, 0, 262, 1, 42);
    expect_run(1, 0, 0, 262, 2, 1);
    expect_run(1, 1, 0, 330, 2, 10);
    expect_run(1, 0, 0, 330, 2, 21);
    expect_run(1, 0, 0, 330, 3, 1);
    expect_run(1, 0, 1, 330, 3, 1);
`ifdef MELODY_LOOP_EN
    expect_run(1, 0, 0, 330, 0, 1);
    expect_run(1, 1, 0, 262, 0, 3);
`endif
    expect_run(0, 0, 0, 0, 0, 0);
    start_b = 1; step(); start_b = 0;
`ifdef MELODY_LOOP_EN
    repeat (121) step();
    stop_b = 1; step(); stop_b = 0;
    repeat (3) step();
`else
    repeat (124) step();
`endif
    end_seq();

    // Stop during the second note: straight to IDLE, no done pulse.
    begin_seq(2);
    expect_run(0, 0, 0, 0, 0, 0);
    expect_run(1, 0, 0, 0, 0, 1);
    expect_run(1, 1, 0, 262, 0, 10);
    expect_run(1, 0, 0, 262, 0, 21);
    expect_run(1, 0, 0, 262, 1, 1);
    expect_run(1, 1, 0, 294, 1, 5);
    expect_run(0, 0, 0, 0, 0, 0);
    start_c = 1; step(); start_c = 0;
    repeat (37) step();
    stop_c = 1; step(); stop_c = 0;
    repeat (5) step();
    end_seq();

    // Start and stop together from IDLE: stays IDLE.
    begin_seq(2);
    expect_run(0, 0, 0, 0, 0, 0);
    start_c = 1; stop_c = 1;
    repeat (3) step();
    start_c = 0; stop_c = 0;
    repeat (3) step();
    end_seq();

    // Full sixteen-entry table: DONE after index 15.
    begin_seq(2);
    expect_run(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 0) expect_run(1, 0, 0, 0, 0, 1);
      else        expect_run(1, 0, 0, mel[i-1], i, 1);
      expect_run(1, 1, 0, mel[i], i, 10);
      expect_run(1, 0, 0, mel[i], i, 21);
    end
    expect_run(1, 0, 1, mel[15], 15, 1);
`ifdef MELODY_LOOP_EN
    expect_run(1, 0, 0, mel[15], 0, 1);
    expect_run(1, 1, 0, mel[0], 0, 2);
`endif
    expect_run(0, 0, 0, 0, 0, 0);
    start_c = 1; step(); start_c = 0;
`ifdef MELODY_LOOP_EN
    repeat (515) step();
    stop_c = 1; step(); stop_c = 0;
    repeat (3) step();
`else
    repeat (520) step();
`endif
    end_seq();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
